// File: rtl/tlc_pkg.sv
// Shared types for the traffic-light command interface: command codes,
// host request modes and the length of the full NORMAL command sequence.
package tlc_pkg;

   typedef enum logic [2:0] {
      CMD_ON         = 3'd0,
      CMD_OFF        = 3'd1,
      CMD_BLINK_Y    = 3'd2,
      CMD_SET_GREEN  = 3'd3,
      CMD_SET_RED    = 3'd4,
      CMD_SET_YELLOW = 3'd5
   } cmd_type_t;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_BLINK  = 2'd1,
      MODE_NORMAL = 2'd2,
      MODE_RSVD   = 2'd3
   } req_mode_t;

   localparam int NORMAL_SEQ_LEN = 5;

endpackage

// File: rtl/traffic_lights_cmd_gen.sv
// Expands one host mode request into the light controller's command sequence.
// Optional TLC_CMD_SKIP_UNCHANGED_EN: skip SET_* commands whose value was already sent.
module traffic_lights_cmd_gen
   import tlc_pkg::*;
#(
   parameter int CMD_GAP = 2,
   parameter int DATA_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        req_mode_i,
   input  logic [DATA_W-1:0] req_green_i,
   input  logic [DATA_W-1:0] req_red_i,
   input  logic [DATA_W-1:0] req_yellow_i,
   output logic [2:0]        cmd_type_o,
   output logic              cmd_valid_o,
   output logic [DATA_W-1:0] cmd_data_o,
   output logic              busy_o,
   output logic              err_o
);

   localparam int GAP_W = (CMD_GAP > 1) ? $clog2(CMD_GAP + 1) : 1;
   localparam logic [2:0] IDX_NONE = 3'(NORMAL_SEQ_LEN);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

   state_t                    state_q;
   req_mode_t                 mode_q, mode_d;
   logic [2:0]                idx_q;
   logic [2:0]                nxt_idx;
   logic [GAP_W-1:0]          gap_q;
   logic [NORMAL_SEQ_LEN-1:0] mask_q, mask_d;
   logic [DATA_W-1:0]         green_q, red_q, yellow_q;
   logic [DATA_W-1:0]         green_d, red_d, yellow_d;
   logic                      err_q, err_d;
   logic                      cmd_valid_q;
   logic [2:0]                cmd_type_q;
   logic [DATA_W-1:0]         cmd_data_q;
   logic                      accept;
`ifdef TLC_CMD_SKIP_UNCHANGED_EN
   logic [DATA_W-1:0]         sh_green_q, sh_red_q, sh_yellow_q;
`endif

   function automatic logic [DATA_W-1:0] clamp_dur(input logic [DATA_W-1:0] v);
      return (v == '0) ? DATA_W'(1) : v;
   endfunction

   function automatic cmd_type_t cmd_at(input req_mode_t m, input logic [2:0] i);
      cmd_type_t c;
      c = CMD_OFF;
      if (m == MODE_BLINK) begin
         c = CMD_BLINK_Y;
      end else if (m == MODE_NORMAL) begin
         case (i)
            3'd0:    c = CMD_BLINK_Y;
            3'd1:    c = CMD_SET_GREEN;
            3'd2:    c = CMD_SET_RED;
            3'd3:    c = CMD_SET_YELLOW;
            default: c = CMD_ON;
         endcase
      end
      return c;
   endfunction

   function automatic logic [DATA_W-1:0] data_at(input logic [2:0] i,
                                                 input logic [DATA_W-1:0] g,
                                                 input logic [DATA_W-1:0] r,
                                                 input logic [DATA_W-1:0] y);
      logic [DATA_W-1:0] d;
      case (i)
         3'd1:    d = g;
         3'd2:    d = r;
         3'd3:    d = y;
         default: d = '0;
      endcase
      return d;
   endfunction

   // Lowest enabled step above i, or IDX_NONE when the sequence is finished.
   function automatic logic [2:0] next_idx(input logic [NORMAL_SEQ_LEN-1:0] m,
                                           input logic [2:0] i);
      logic [2:0] r;
      r = IDX_NONE;
      for (int j = NORMAL_SEQ_LEN - 1; j >= 0; j--) begin
         if (m[j] && (3'(j) > i)) r = 3'(j);
      end
      return r;
   endfunction

   assign accept  = req_valid_i && (state_q == ST_IDLE);
   assign nxt_idx = next_idx(mask_q, idx_q);

   always_comb begin
      mode_d   = MODE_OFF;
      err_d    = err_q;
      mask_d   = NORMAL_SEQ_LEN'(1);
      green_d  = clamp_dur(req_green_i);
      red_d    = clamp_dur(req_red_i);
      yellow_d = clamp_dur(req_yellow_i);
      case (req_mode_i)
         2'd1: mode_d = MODE_BLINK;
         2'd2: begin
            mode_d = MODE_NORMAL;
            mask_d = '1;
            if ((req_green_i == '0) || (req_red_i == '0) || (req_yellow_i == '0))
               err_d = 1'b1;
`ifdef TLC_CMD_SKIP_UNCHANGED_EN
            mask_d[1] = (green_d  != sh_green_q);
            mask_d[2] = (red_d    != sh_red_q);
            mask_d[3] = (yellow_d != sh_yellow_q);
`endif
         end
         2'd3: err_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_OFF;
         idx_q       <= '0;
         gap_q       <= '0;
         mask_q      <= '0;
         green_q     <= '0;
         red_q       <= '0;
         yellow_q    <= '0;
         err_q       <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_type_q  <= '0;
         cmd_data_q  <= '0;
`ifdef TLC_CMD_SKIP_UNCHANGED_EN
         sh_green_q  <= '0;
         sh_red_q    <= '0;
         sh_yellow_q <= '0;
`endif
      end else begin
         cmd_valid_q <= 1'b0;
         cmd_type_q  <= '0;
         cmd_data_q  <= '0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  mode_q      <= mode_d;
                  green_q     <= green_d;
                  red_q       <= red_d;
                  yellow_q    <= yellow_d;
                  mask_q      <= mask_d;
                  err_q       <= err_d;
                  idx_q       <= '0;
                  state_q     <= ST_ISSUE;
                  cmd_valid_q <= 1'b1;
                  cmd_type_q  <= cmd_at(mode_d, 3'd0);
               end
            end
            ST_ISSUE: begin
`ifdef TLC_CMD_SKIP_UNCHANGED_EN
               if (mode_q == MODE_NORMAL) begin
                  case (idx_q)
                     3'd1:    sh_green_q  <= green_q;
                     3'd2:    sh_red_q    <= red_q;
                     3'd3:    sh_yellow_q <= yellow_q;
                     default: ;
                  endcase
               end
`endif
               if (nxt_idx == IDX_NONE) begin
                  state_q <= ST_IDLE;
                  idx_q   <= '0;
               end else if (CMD_GAP > 0) begin
                  state_q <= ST_GAP;
                  gap_q   <= GAP_W'(CMD_GAP - 1);
                  idx_q   <= nxt_idx;
               end else begin
                  idx_q       <= nxt_idx;
                  cmd_valid_q <= 1'b1;
                  cmd_type_q  <= cmd_at(mode_q, nxt_idx);
                  cmd_data_q  <= data_at(nxt_idx, green_q, red_q, yellow_q);
               end
            end
            ST_GAP: begin
               if (gap_q == '0) begin
                  state_q     <= ST_ISSUE;
                  cmd_valid_q <= 1'b1;
                  cmd_type_q  <= cmd_at(mode_q, idx_q);
                  cmd_data_q  <= data_at(idx_q, green_q, red_q, yellow_q);
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);
   assign cmd_valid_o = cmd_valid_q;
   assign cmd_type_o  = cmd_type_q;
   assign cmd_data_o  = cmd_data_q;
   assign err_o       = err_q;

endmodule

// File: doc/traffic_lights_cmd_gen.md
Name: traffic_lights_cmd_gen

Overview:
Command initiator for the traffic-light controller's command interface (cmd_type/cmd_valid/cmd_data).
- Accepts one high-level mode request (OFF, BLINK, NORMAL with green/red/yellow durations) over a valid/ready handshake.
- Expands the request into the correct ordered command sequence, spaced by a programmable idle gap.
- Sits between the host/config logic and the light controller; drives its command inputs directly.

Parameters:
CMD_GAP, 2, idle cycles inserted between consecutive command pulses; 0 means back-to-back pulses.
DATA_W, 16, width of cmd_data_o and the duration fields.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
req_valid_i  in  1  host request valid
req_ready_o  out  1  block can accept a request
req_mode_i  in  2  0=OFF, 1=BLINK, 2=NORMAL; 3 is reserved
req_green_i  in  DATA_W  green duration in ms (NORMAL only)
req_red_i  in  DATA_W  red duration in ms (NORMAL only)
req_yellow_i  in  DATA_W  yellow duration in ms (NORMAL only)
cmd_type_o  out  3  command code: 0 ON, 1 OFF, 2 BLINK_Y, 3 SET_GREEN, 4 SET_RED, 5 SET_YELLOW
cmd_valid_o  out  1  one-cycle command strobe
cmd_data_o  out  DATA_W  duration for SET_* commands; 0 otherwise
busy_o  out  1  sequence in progress
err_o  out  1  sticky: a zero duration or a reserved mode was seen

Behaviour:
Reset values: all outputs 0 except req_ready_o=1. Internal state is IDLE; the index and gap counters are 0.

Handshake:
- Accept when req_valid_i & req_ready_o.
- Mode and durations are latched on acceptance; later input changes are ignored.
- req_ready_o = (state==IDLE).

Latency: the first cmd_valid_o pulse occurs in the cycle after acceptance.

Sequences:
- OFF: [1].
- BLINK: [2].
- NORMAL: [2, 3(green), 4(red), 5(yellow), 0].

Command timing:
- Each command is a single-cycle cmd_valid_o=1 with cmd_type_o and cmd_data_o stable.
- Between pulses cmd_valid_o=0 for exactly CMD_GAP cycles.
- cmd_type_o and cmd_data_o are 0 whenever cmd_valid_o=0.

FSM states:
- IDLE: -> ISSUE on accept.
- ISSUE: emits the current command.
  - -> GAP if more commands remain and CMD_GAP>0.
  - -> ISSUE (index+1) if more commands remain and CMD_GAP==0.
  - -> IDLE after the last command.
- GAP: counts CMD_GAP-1 down to 0, then -> ISSUE with index+1.

busy_o = (state != IDLE). req_ready_o returns to 1 in the cycle after the last pulse.

Boundaries:
- Zero duration in NORMAL: sent as 1, err_o set.
- Reserved mode 3: treated as OFF, err_o set.
- err_o clears only on reset.
- Requests are not accepted while busy; there is no queueing.
- Reset asserted mid-sequence: outputs return to reset values immediately (asynchronously) and the partially sent sequence is abandoned.
- The gap counter must hold CMD_GAP; the index counter is 3 bits and never wraps, because the index is bounded by the sequence length.

Optional Feature:
Macro TLC_CMD_SKIP_UNCHANGED_EN.
- Defined: shadow registers hold the last sent green/red/yellow values (reset to 0). In NORMAL, any SET_* command whose clamped value equals its shadow is skipped, along with its following gap. Shadows update when a SET_* command is sent. The sequence length varies from 2 to 5 commands.
- Not defined: the full 5-command NORMAL sequence is always sent and no shadow registers exist.

Decomposition:
Shared package tlc_pkg contains:
- cmd_type_t enum (3-bit codes above).
- req_mode_t enum (2-bit).
- NORMAL_SEQ_LEN = 5.

No sub-module: the FSM and counters stay in a single module.

Test Plan:
1. Reset, then NORMAL with green=10, red=20, yellow=3, CMD_GAP=2 -> pulses at cycles t+1, t+4, t+7, t+10, t+13 with (type,data) = (2,0), (3,10), (4,20), (5,3), (0,0); req_ready_o back to 1 at t+14.
2. OFF request, then BLINK, with CMD_GAP=0 -> single pulses type 1, then type 2, each exactly 1 cycle; busy_o high for 1 cycle each.
3. NORMAL with green=0 -> SET_GREEN data=1, err_o=1 and stays 1 through a following clean request.
4. Reset asserted during the gap after SET_RED -> cmd_valid_o=0 and busy_o=0 immediately; after release, NORMAL restarts cleanly from (2,0).
5. req_valid_i held high while busy, with changing durations -> no accept until IDLE; the latched values of the first request are sent.
6. TLC_CMD_SKIP_UNCHANGED_EN: NORMAL 10/20/3 twice, then 10/25/3 -> 2nd sequence is (2),(0); 3rd sequence is (2),(4,25),(0).
